// File: rtl/temporal_ngram_encoder_pkg.sv
// temporal_ngram_encoder_pkg: shared hypervector constants and window state type.
package temporal_ngram_encoder_pkg;
   localparam int HV_DIMENSION = 1024;
   localparam int NGRAM_SIZE = 3;
   typedef enum logic {FILL, STEADY} state_e;
endpackage

// File: rtl/temporal_ngram_encoder_permute.sv
// hv_permute: combinational rotation rho^SHIFT, out[j] = in[(j-SHIFT) mod DIM].
module hv_permute #(
   parameter int DIM = 8,
   parameter int SHIFT = 1
) (
   input  logic [0:DIM-1] In_DI,
   output logic [0:DIM-1] Out_DO
);
   for (genvar j = 0; j < DIM; j++) begin : g_bit
      assign Out_DO[j] = In_DI[(j + DIM - (SHIFT % DIM)) % DIM];
   end
endmodule

// File: rtl/temporal_ngram_encoder.sv
// temporal_ngram_encoder: binds the last NGRAM spatial hypervectors into a temporal N-gram
// with a valid/ready registered output.
module temporal_ngram_encoder
   import temporal_ngram_encoder_pkg::*;
#(
   parameter int DIM = HV_DIMENSION,
   parameter int NGRAM = NGRAM_SIZE,
   parameter int CNT_W = 3
) (
   input  logic           Clk_CI,
   input  logic           Reset_RI,
   input  logic           Clear_SI,
   input  logic           ValidIn_SI,
   output logic           ReadyOut_SO,
   input  logic [0:DIM-1] HypervectorIn_DI,
   output logic           ValidOut_SO,
   input  logic           ReadyIn_SI,
   output logic [0:DIM-1] NGramOut_DO,
   output logic           Filled_SO
);
   localparam int HL = (NGRAM > 1) ? NGRAM - 1 : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NGRAM - 1);
   logic [0:DIM-1] hist_q [HL];
   logic [0:DIM-1] hist_d [HL];
   logic [0:DIM-1] tap [NGRAM];
   logic [0:DIM-1] ng, ngram_q, ngram_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic valid_q, valid_d, acc, steady;
   state_e state_q, state_d;
   assign tap[0] = HypervectorIn_DI;
   for (genvar k = 1; k < NGRAM; k++) begin : g_tap
      hv_permute #(.DIM(DIM), .SHIFT(k)) u_perm (.In_DI(hist_q[k-1]), .Out_DO(tap[k]));
   end
   always_comb begin
      ng = '0;
      for (int k = 0; k < NGRAM; k++) ng ^= tap[k];
   end
   assign ReadyOut_SO = ~Clear_SI & (~valid_q | ReadyIn_SI);
   assign acc = ValidIn_SI & ReadyOut_SO;
   assign steady = fill_q == LAST;
   // A consume and a load in the same cycle keep valid high with fresh data.
   always_comb begin
      hist_d = hist_q;
      if (acc) begin
         hist_d[0] = HypervectorIn_DI;
         for (int k = 1; k < HL; k++) hist_d[k] = hist_q[k-1];
      end
      fill_d = (acc && !steady) ? fill_q + 1'b1 : fill_q;
      valid_d = (acc && steady) ? 1'b1 : (ReadyIn_SI ? 1'b0 : valid_q);
      ngram_d = (acc && steady) ? ng : ngram_q;
      state_d = (fill_d == LAST) ? STEADY : FILL;
   end
   always_ff @(posedge Clk_CI) begin
      if (Reset_RI) begin
         hist_q <= '{default: '0};
         fill_q <= '0;
         valid_q <= 1'b0;
         ngram_q <= '0;
         state_q <= FILL;
      end else if (Clear_SI) begin
         hist_q <= '{default: '0};
         fill_q <= '0;
         valid_q <= 1'b0;
         state_q <= FILL;
      end else begin
         hist_q <= hist_d;
         fill_q <= fill_d;
         valid_q <= valid_d;
         ngram_q <= ngram_d;
         state_q <= state_d;
      end
   end
   assign ValidOut_SO = valid_q;
   assign NGramOut_DO = ngram_q;
   assign Filled_SO = state_q == STEADY;
endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// tb_temporal_ngram_encoder: directed checks of an NGRAM=3 and an NGRAM=1 encoder at DIM=8.
module tb_temporal_ngram_encoder;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int total = 0;
   int bad = 0;
   logic rst, clr, vin, rdy_in;
   logic [0:7] din;
   logic rdy_out, vout, filled;
   logic [0:7] ng;
   logic rst2, vin2, rdy_in2;
   logic [0:7] din2;
   logic rdy_out2, vout2, filled2;
   logic [0:7] ng2;
   temporal_ngram_encoder #(.DIM(8), .NGRAM(3), .CNT_W(3)) dut (
      .Clk_CI(clk), .Reset_RI(rst), .Clear_SI(clr), .ValidIn_SI(vin), .ReadyOut_SO(rdy_out),
      .HypervectorIn_DI(din), .ValidOut_SO(vout), .ReadyIn_SI(rdy_in), .NGramOut_DO(ng),
      .Filled_SO(filled)
   );
   temporal_ngram_encoder #(.DIM(8), .NGRAM(1), .CNT_W(3)) dut1 (
      .Clk_CI(clk), .Reset_RI(rst2), .Clear_SI(1'b0), .ValidIn_SI(vin2), .ReadyOut_SO(rdy_out2),
      .HypervectorIn_DI(din2), .ValidOut_SO(vout2), .ReadyIn_SI(rdy_in2), .NGramOut_DO(ng2),
      .Filled_SO(filled2)
   );
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask
   task automatic step();
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1; rst2 = 1; clr = 0; vin = 0; rdy_in = 0; din = '0;
      vin2 = 0; rdy_in2 = 0; din2 = '0;
      step(); step();
      rst = 0; rst2 = 0;
      chk("rst_valid", vout, 0);
      chk("rst_ng", ng, 8'b00000000);
      chk("rst_filled", filled, 0);
      chk("rst_ready", rdy_out, 1);
      step();
      chk("idle_valid", vout, 0);
      rdy_in = 1; vin = 1;
      din = 8'b10000000; step();
      chk("after_A_valid", vout, 0);
      chk("after_A_filled", filled, 0);
      din = 8'b00000000; step();
      chk("after_B_valid", vout, 0);
      chk("after_B_filled", filled, 1);
      din = 8'b00000000; step();
      chk("C_valid", vout, 1);
      chk("C_ng", ng, 8'b00100000);
      chk("C_filled", filled, 1);
      din = 8'b00000001; step();
      chk("D_valid", vout, 1);
      chk("D_ng", ng, 8'b00000001);
      din = 8'b00000000; step();
      chk("E_valid", vout, 1);
      chk("E_ng", ng, 8'b10000000);
      rdy_in = 0; din = 8'b00010000;
      #1;
      chk("stall_ready", rdy_out, 0);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_valid", vout, 1);
         chk("stall_ng", ng, 8'b10000000);
      end
      rdy_in = 1;
      #1;
      chk("release_ready", rdy_out, 1);
      step();
      chk("F_valid", vout, 1);
      chk("F_ng", ng, 8'b01010000);
      rdy_in = 0; clr = 1; din = 8'b11111111;
      #1;
      chk("clear_ready", rdy_out, 0);
      step();
      clr = 0; rdy_in = 1;
      chk("clear_valid", vout, 0);
      chk("clear_filled", filled, 0);
      din = 8'b01000000; step();
      chk("G1_valid", vout, 0);
      din = 8'b00000000; step();
      chk("G2_valid", vout, 0);
      din = 8'b00000000; step();
      chk("G3_valid", vout, 1);
      chk("G3_ng", ng, 8'b00010000);
      vin = 0; step();
      chk("drain_valid", vout, 0);
      chk("drain_ng_hold", ng, 8'b00010000);
      vin2 = 1; rdy_in2 = 1; din2 = 8'b01010101; step();
      chk("n1_valid", vout2, 1);
      chk("n1_ng", ng2, 8'b01010101);
      din2 = 8'b00110011; step();
      chk("n1_ng2", ng2, 8'b00110011);
      chk("n1_filled", filled2, 1);
      rst2 = 1; step();
      rst2 = 0; vin2 = 0;
      chk("n1_rst_valid", vout2, 0);
      chk("n1_rst_ng", ng2, 8'b00000000);
      chk("n1_rst_filled", filled2, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/temporal_ngram_encoder.md
Name: temporal_ngram_encoder

Overview:
- Sits directly downstream of the spatial accumulator.
- Receives one spatial hypervector per time sample and binds the most recent NGRAM samples into a temporal N-gram hypervector: out = H(t) XOR rho(H(t-1)) XOR rho^2(H(t-2)) XOR ... XOR rho^(NGRAM-1)(H(t-NGRAM+1)).
- Result feeds the associative memory / similarity stage through a valid/ready output register.

Parameters:
- DIM, `HV_DIMENSION, hypervector width in bits (index order [0:DIM-1]).
- NGRAM, 3, N-gram length. Legal range 1..8.
- CNT_W, 3, fill-counter width. Must satisfy 2^CNT_W >= NGRAM.

Ports:
- Clk_CI  in  1  clock.
- Reset_RI  in  1  synchronous active-high reset.
- Clear_SI  in  1  synchronous restart of the N-gram window (new trial).
- ValidIn_SI  in  1  spatial hypervector on HypervectorIn_DI is valid.
- ReadyOut_SO  out  1  block accepts an input this cycle.
- HypervectorIn_DI  in  DIM  spatial hypervector from the accumulator majority output.
- ValidOut_SO  out  1  NGramOut_DO holds a complete N-gram.
- ReadyIn_SI  in  1  downstream accepts the output.
- NGramOut_DO  out  DIM  registered N-gram hypervector.
- Filled_SO  out  1  history window is full (STEADY state).

Behaviour:
- Permutation: rho(x) = {x[DIM-1], x[0:DIM-2]}, i.e. rho(x)[j] = x[(j-1) mod DIM]. rho^k is k applications, a pure wire rotation with no logic.
- History: History[0..NGRAM-2], where History[0] is the most recently accepted sample. Fill counter FillCnt counts 0..NGRAM-1 and saturates.
- Accept condition: Acc = ValidIn_SI & ReadyOut_SO.
  - ReadyOut_SO = ~Clear_SI & (~ValidOut_SO | ReadyIn_SI).
- On Acc:
  - History shifts: History[k] <= History[k-1]; History[0] <= HypervectorIn_DI.
  - FillCnt increments, saturating at NGRAM-1.
- Combinational N-gram: NG = HypervectorIn_DI XOR (XOR over k=1..NGRAM-1 of rho^k(History[k-1])).
- States:
  - FILL (FillCnt < NGRAM-1): accepted samples update history only; no output.
  - STEADY (FillCnt == NGRAM-1): each accepted sample loads NGramOut_DO <= NG and sets ValidOut_SO.
  - FILL -> STEADY on the accept that brings FillCnt to NGRAM-1. That sample does not itself produce output. The first output comes from the NGRAM-th sample.
  - STEADY -> FILL only on Clear_SI or Reset_RI.
- NGRAM == 1: always STEADY; output equals input, one-cycle latency.
- Latency: one cycle from accept of a STEADY-state sample to ValidOut_SO=1.
- Output handshake: ValidOut_SO drops when ValidOut_SO & ReadyIn_SI and no new load occurs that cycle. A simultaneous consume and load keeps ValidOut_SO=1 with the new data, giving a full-throughput sample per cycle. NGramOut_DO is stable while ValidOut_SO & ~ReadyIn_SI.
- Clear_SI:
  - FillCnt <= 0, all History <= 0, ValidOut_SO <= 0. A pending output is discarded.
  - An input presented the same cycle is not accepted (ReadyOut_SO=0).
- Reset_RI: ValidOut_SO=0, NGramOut_DO=0, all History=0, FillCnt=0, Filled_SO=0. Reset has priority over Clear_SI and all traffic.
- Filled_SO is registered and equals (FillCnt == NGRAM-1).

Decomposition:
- Shared const.vh: `HV_DIMENSION and a default `NGRAM_SIZE constant. No new typedefs.
- One natural sub-module: hv_permute (parameters DIM, SHIFT), a combinational rotate-by-SHIFT, instantiated once per history tap.

Test Plan (DIM=8 override, NGRAM=3; vectors written bit0..bit7):
- Reset, then idle -> ValidOut_SO=0, NGramOut_DO=00000000, Filled_SO=0, ReadyOut_SO=1.
- Feed A=10000000, B=00000000, C=00000000 back-to-back with ReadyIn_SI=1 -> no output after A or B; one cycle after C: ValidOut_SO=1, NGramOut_DO=00100000 (A rotated by 2), Filled_SO=1.
- Continue with D=00000001 -> next output = D ^ rho(C) ^ rho^2(B) = 00000001. Then E=00000000 -> output = rho(D) = 10000000.
- Hold ReadyIn_SI=0 while an output is pending and ValidIn_SI=1 -> ReadyOut_SO=0, NGramOut_DO unchanged for 5 cycles. Release ReadyIn_SI -> the queued sample is accepted the same cycle and the next N-gram follows one cycle later.
- Assert Clear_SI with ValidIn_SI=1 and a pending output -> input not accepted, ValidOut_SO=0 next cycle, Filled_SO=0. Three new samples are again required before the next output.
- NGRAM=1 build: input 01010101 -> output 01010101 one cycle later. Assert Reset_RI mid-stream -> all outputs return to zero the next cycle.
